sync_mux_arb: RTL and testbench
===============================

// Module: sync_mux_arb
// PURPOSE
//  Parametrised successor to the 16-bit 2:1 registered mux. Selects one of N_CH WIDTH-bit
//  channels and drives it through a single output register with valid/ready handshake.
//  Selection is by explicit address or by round-robin arbitration, chosen at run time.
//  Sits between multiple producers and one consumer on the datapath, e.g. a shared sink.
// PARAMETERS
//  WIDTH  16  data width per channel
//  N_CH   4   number of input channels, >=2; SEL_W = $clog2(N_CH) (localparam)
// PORTS
//  clk        in   1            clock; all logic on rising edge
//  clr        in   1            synchronous, active-high reset
//  in_data    in   N_CH*WIDTH   channel i at [i*WIDTH +: WIDTH]
//  in_valid   in   N_CH         channel i holds a word
//  in_ready   out  N_CH         channel i word accepted this cycle (valid&ready)
//  mode       in   1            0 = addressed, 1 = round-robin
//  addr       in   SEL_W        channel select in addressed mode
//  out_data   out  WIDTH        registered selected word
//  out_ch     out  SEL_W        channel index of out_data
//  out_valid  out  1            out_data/out_ch hold a word
//  out_ready  in   1            consumer accepts when out_valid&out_ready
// BEHAVIOUR
//  - One clock, one reset. clr sampled on posedge clk, overrides all else.
//  - Reset: out_valid=0, out_data=0, out_ch=0, rr_ptr=N_CH-1 (ch0 highest prio first).
//  - load = !out_valid | out_ready (register empty or draining this cycle).
//  - Addressed: grant = addr if addr<N_CH and in_valid[addr]; else no grant.
//    addr>=N_CH (non-power-of-2 N_CH) -> no grant, no in_ready, no error flag.
//  - Round-robin: search from (rr_ptr+1) mod N_CH upward with wrap; first valid channel
//    wins. rr_ptr <= granted index only on an accepted transfer; else unchanged.
//  - in_ready[i] = load & grant_valid & (grant==i); at most one bit set; combinational
//    from in_valid/mode/addr/out_valid/out_ready/rr_ptr. Must not depend on in_data.
//  - Transfer in: out_data<=word, out_ch<=grant, out_valid<=1. Latency 1 cycle.
//  - load & no grant: out_valid<=0; out_data/out_ch keep last value.
//  - out_valid & !out_ready: out_data, out_ch, out_valid held stable; all in_ready=0.
//  - Simultaneous drain+fill: out_ready=1 with new grant -> back-to-back, 1 word/cycle.
//  - mode/addr changes take effect in the same cycle's arbitration; rr_ptr preserved
//    across mode changes (not updated by addressed-mode transfers).
//  - clr mid-transfer: held word discarded, in_ready=0 during clr cycle, state -> reset.
//  - No combinational path from in_data to outputs; no FIFO beyond the one register.
// TESTING
//  1 clr=1 2 cycles, then release -> out_valid=0, out_data=0, out_ch=0, in_ready=0.
//  2 mode=0, addr=2, in_valid=4'b0100, in_data[2]=16'hBEEF, out_ready=1 -> next cycle
//    out_valid=1, out_data=16'hBEEF, out_ch=2; in_ready=4'b0100 in the load cycle.
//  3 mode=1, in_valid=4'b1111 held, out_ready=1 -> out_ch sequence 0,1,2,3,0, one per
//    cycle, no bubbles.
//  4 mode=1, in_valid=4'b1010 -> out_ch 1,3,1,3; then out_ready=0 3 cycles -> out_data,
//    out_ch stable, in_ready=0; resume -> next grant continues the rotation.
//  5 N_CH=3, mode=0, addr=3, in_valid=3'b111 -> in_ready=0, out_valid stays 0.
//  6 out_valid=1, out_ready=0, assert clr 1 cycle -> out_valid=0 next cycle, word lost,
//    rr_ptr=N_CH-1 (next rr grant with all valid is ch0).

Source files
------------

// File: rtl/sync_mux_arb_if.sv
// Handshake bundle between N_CH producers, the run-time mode/address controls,
// and the single registered consumer port of sync_mux_arb.
interface sync_mux_arb_if #(
    parameter int WIDTH = 16,
    parameter int N_CH  = 4
);
    localparam int SEL_W = $clog2(N_CH);

    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_ready;
    logic                  mode;
    logic [SEL_W-1:0]      addr;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_ch;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_data, in_valid, mode, addr, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  in_data, in_valid, mode, addr, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/sync_mux_arb.sv
// N_CH:1 registered mux with valid/ready handshake; the source channel is picked
// either by explicit address or by round-robin arbitration, selectable at run time.
module sync_mux_arb #(
    parameter int WIDTH = 16,
    parameter int N_CH  = 4
) (
    input logic            clk,
    input logic            clr,
    sync_mux_arb_if.slave  bus
);
    localparam int SEL_W = $clog2(N_CH);

    logic [WIDTH-1:0] data_p0;
    logic [SEL_W-1:0] ch_p0;
    logic             vld_p0;
    logic [SEL_W-1:0] rr_ptr;

    logic             load;
    logic             grant_valid;
    logic [SEL_W-1:0] grant;
    logic [SEL_W-1:0] rr_idx;
    logic [WIDTH-1:0] sel_word;
    logic [N_CH-1:0]  in_ready_c;

    assign load = !vld_p0 || bus.out_ready;

    // Arbitration: the round-robin search runs from the farthest candidate down to
    // the nearest, so the last hit written is the first one in rotation order.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        rr_idx      = '0;
        if (!bus.mode) begin
            for (int i = 0; i < N_CH; i++) begin
                if (bus.addr == SEL_W'(i) && bus.in_valid[i]) begin
                    grant       = SEL_W'(i);
                    grant_valid = 1'b1;
                end
            end
        end else begin
            for (int k = N_CH; k >= 1; k--) begin
                rr_idx = SEL_W'((int'(rr_ptr) + k) % N_CH);
                if (bus.in_valid[rr_idx]) begin
                    grant       = rr_idx;
                    grant_valid = 1'b1;
                end
            end
        end
    end

    // Data steering is kept apart from the handshake so in_ready never sees in_data.
    always_comb begin
        sel_word = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant == SEL_W'(i)) sel_word = bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        in_ready_c = '0;
        for (int i = 0; i < N_CH; i++) begin
            in_ready_c[i] = !clr && load && grant_valid && (grant == SEL_W'(i));
        end
    end

    assign bus.in_ready = in_ready_c;

    // Stage p0: the single output register
    always_ff @(posedge clk) begin
        if (clr) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            ch_p0   <= '0;
            rr_ptr  <= SEL_W'(N_CH - 1);
        end else if (load) begin
            if (grant_valid) begin
                data_p0 <= sel_word;
                ch_p0   <= grant;
                vld_p0  <= 1'b1;
                if (bus.mode) rr_ptr <= grant;
            end else begin
                vld_p0 <= 1'b0;
            end
        end
    end

    assign bus.out_data  = data_p0;
    assign bus.out_ch    = ch_p0;
    assign bus.out_valid = vld_p0;
endmodule

// File: tb/tb_sync_mux_arb.sv
// Directed bench for sync_mux_arb: a 4-channel instance for the main scenarios and
// a 3-channel instance for out-of-range addressing and non-power-of-2 wrap.
module tb_sync_mux_arb;
    logic clk;
    logic clr;
    int   n_checks;
    int   n_fail;

    sync_mux_arb_if #(.WIDTH(16), .N_CH(4)) bus4 ();
    sync_mux_arb_if #(.WIDTH(16), .N_CH(3)) bus3 ();

    sync_mux_arb #(.WIDTH(16), .N_CH(4)) dut4 (.clk(clk), .clr(clr), .bus(bus4));
    sync_mux_arb #(.WIDTH(16), .N_CH(3)) dut3 (.clk(clk), .clr(clr), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        clr = 1'b1;
        bus4.in_valid = 4'b1111; bus4.mode = 1'b0; bus4.addr = 2'd0; bus4.out_ready = 1'b1;
        bus3.in_valid = 3'b111;  bus3.mode = 1'b0; bus3.addr = 2'd0; bus3.out_ready = 1'b1;
        tick();
        n_checks++;
        if (bus4.in_ready !== 4'b0000) begin
            n_fail++; $display("FAIL reset_in_ready4: got %b want 0000", bus4.in_ready);
        end
        n_checks++;
        if (bus3.in_ready !== 3'b000) begin
            n_fail++; $display("FAIL reset_in_ready3: got %b want 000", bus3.in_ready);
        end
        tick();
        clr = 1'b0;
        bus4.in_valid = '0;
        bus3.in_valid = '0;
        #1;
        n_checks++;
        if (bus4.out_valid !== 1'b0 || bus4.out_data !== 16'h0000 || bus4.out_ch !== 2'd0) begin
            n_fail++; $display("FAIL reset_outputs: got v=%b d=%h ch=%0d want v=0 d=0000 ch=0",
                               bus4.out_valid, bus4.out_data, bus4.out_ch);
        end
        n_checks++;
        if (bus4.in_ready !== 4'b0000 || bus3.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: got rdy=%b v3=%b want 0000/0",
                               bus4.in_ready, bus3.out_valid);
        end
    endtask

    task automatic test_addressed;
        bus4.mode = 1'b0; bus4.addr = 2'd2; bus4.out_ready = 1'b1;
        bus4.in_data = {16'h3333, 16'hBEEF, 16'h2222, 16'h1111};
        bus4.in_valid = 4'b0100;
        #1;
        n_checks++;
        if (bus4.in_ready !== 4'b0100) begin
            n_fail++; $display("FAIL addr_in_ready: got %b want 0100", bus4.in_ready);
        end
        tick();
        n_checks++;
        if (bus4.out_valid !== 1'b1 || bus4.out_data !== 16'hBEEF || bus4.out_ch !== 2'd2) begin
            n_fail++; $display("FAIL addr_out: got v=%b d=%h ch=%0d want v=1 d=beef ch=2",
                               bus4.out_valid, bus4.out_data, bus4.out_ch);
        end
        bus4.in_valid = 4'b0000;
        #1;
        n_checks++;
        if (bus4.in_ready !== 4'b0000) begin
            n_fail++; $display("FAIL addr_idle_rdy: got %b want 0000", bus4.in_ready);
        end
        tick();
        n_checks++;
        if (bus4.out_valid !== 1'b0 || bus4.out_data !== 16'hBEEF || bus4.out_ch !== 2'd2) begin
            n_fail++; $display("FAIL addr_drain: got v=%b d=%h ch=%0d want v=0 d=beef ch=2",
                               bus4.out_valid, bus4.out_data, bus4.out_ch);
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        bus4.mode = 1'b1; bus4.out_ready = 1'b1;
        bus4.in_data = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
        bus4.in_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if (bus4.in_ready !== (4'b0001 << exp_seq[c])) begin
                n_fail++; $display("FAIL rr_in_ready[%0d]: got %b want ch%0d", c, bus4.in_ready, exp_seq[c]);
            end
            tick();
            n_checks++;
            if (bus4.out_valid !== 1'b1 || bus4.out_ch !== exp_seq[c] ||
                bus4.out_data !== (16'hA000 + 16'(exp_seq[c]))) begin
                n_fail++; $display("FAIL rr_out[%0d]: got v=%b ch=%0d d=%h want v=1 ch=%0d",
                                   c, bus4.out_valid, bus4.out_ch, bus4.out_data, exp_seq[c]);
            end
        end
    endtask

    task automatic test_back_to_back_stall;
        logic [1:0] exp_seq [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
        bus4.in_valid = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++;
            if (bus4.out_valid !== 1'b1 || bus4.out_ch !== exp_seq[c] ||
                bus4.out_data !== (16'hA000 + 16'(exp_seq[c]))) begin
                n_fail++; $display("FAIL sparse_rr[%0d]: got v=%b ch=%0d d=%h want ch=%0d",
                                   c, bus4.out_valid, bus4.out_ch, bus4.out_data, exp_seq[c]);
            end
        end
        bus4.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (bus4.in_ready !== 4'b0000) begin
                n_fail++; $display("FAIL stall_rdy[%0d]: got %b want 0000", c, bus4.in_ready);
            end
            tick();
            n_checks++;
            if (bus4.out_valid !== 1'b1 || bus4.out_ch !== 2'd3 || bus4.out_data !== 16'hA003) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got v=%b ch=%0d d=%h want v=1 ch=3 d=a003",
                                   c, bus4.out_valid, bus4.out_ch, bus4.out_data);
            end
        end
        bus4.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus4.in_ready !== 4'b0010) begin
            n_fail++; $display("FAIL resume_rdy: got %b want 0010", bus4.in_ready);
        end
        tick();
        n_checks++;
        if (bus4.out_ch !== 2'd1 || bus4.out_data !== 16'hA001) begin
            n_fail++; $display("FAIL resume_out: got ch=%0d d=%h want ch=1 d=a001", bus4.out_ch, bus4.out_data);
        end
    endtask

    task automatic test_bad_addr;
        logic [1:0] exp_seq [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        bus3.mode = 1'b0; bus3.addr = 2'd3; bus3.out_ready = 1'b1;
        bus3.in_data = {16'hC002, 16'hC001, 16'hC000};
        bus3.in_valid = 3'b111;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if (bus3.in_ready !== 3'b000) begin
                n_fail++; $display("FAIL badaddr_rdy[%0d]: got %b want 000", c, bus3.in_ready);
            end
            tick();
            n_checks++;
            if (bus3.out_valid !== 1'b0) begin
                n_fail++; $display("FAIL badaddr_valid[%0d]: got %b want 0", c, bus3.out_valid);
            end
        end
        bus3.addr = 2'd2;
        #1;
        n_checks++;
        if (bus3.in_ready !== 3'b100) begin
            n_fail++; $display("FAIL n3_addr_rdy: got %b want 100", bus3.in_ready);
        end
        tick();
        n_checks++;
        if (bus3.out_valid !== 1'b1 || bus3.out_ch !== 2'd2 || bus3.out_data !== 16'hC002) begin
            n_fail++; $display("FAIL n3_addr_out: got v=%b ch=%0d d=%h want v=1 ch=2 d=c002",
                               bus3.out_valid, bus3.out_ch, bus3.out_data);
        end
        bus3.mode = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++;
            if (bus3.out_ch !== exp_seq[c] || bus3.out_data !== (16'hC000 + 16'(exp_seq[c]))) begin
                n_fail++; $display("FAIL n3_rr[%0d]: got ch=%0d d=%h want ch=%0d",
                                   c, bus3.out_ch, bus3.out_data, exp_seq[c]);
            end
        end
        bus3.in_valid = 3'b000;
    endtask

    task automatic test_clr_midflight;
        bus4.in_valid = 4'b1111; bus4.out_ready = 1'b0;
        #1;
        n_checks++;
        if (bus4.out_valid !== 1'b1 || bus4.out_ch !== 2'd1) begin
            n_fail++; $display("FAIL pre_clr_state: got v=%b ch=%0d want v=1 ch=1", bus4.out_valid, bus4.out_ch);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_checks++;
        if (bus4.out_valid !== 1'b0 || bus4.out_data !== 16'h0000 || bus4.out_ch !== 2'd0) begin
            n_fail++; $display("FAIL clr_flush: got v=%b d=%h ch=%0d want v=0 d=0000 ch=0",
                               bus4.out_valid, bus4.out_data, bus4.out_ch);
        end
        bus4.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus4.in_ready !== 4'b0001) begin
            n_fail++; $display("FAIL clr_rrptr_rdy: got %b want 0001", bus4.in_ready);
        end
        tick();
        n_checks++;
        if (bus4.out_valid !== 1'b1 || bus4.out_ch !== 2'd0 || bus4.out_data !== 16'hA000) begin
            n_fail++; $display("FAIL clr_rrptr_out: got v=%b ch=%0d d=%h want v=1 ch=0 d=a000",
                               bus4.out_valid, bus4.out_ch, bus4.out_data);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clr = 1'b1;
        bus4.in_data = '0; bus4.in_valid = '0; bus4.mode = 1'b0; bus4.addr = '0; bus4.out_ready = 1'b0;
        bus3.in_data = '0; bus3.in_valid = '0; bus3.mode = 1'b0; bus3.addr = '0; bus3.out_ready = 1'b0;
        test_reset();
        test_bad_addr();
        test_addressed();
        test_round_robin();
        test_back_to_back_stall();
        test_clr_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
